// File: rtl/calc_display_pkg.sv
// calc_display_pkg
// Shared constants for the calculator display driver.
//   NUM_POS    : number of multiplexed display positions (fixed)
//   SEG_BLANK  : all segments off
//   SEG_MINUS  : only segment g lit
//   SEG_E      : "E" pattern shown for invalid BCD codes
//   DIGIT_SEG  : active-low {g,f,e,d,c,b,a} patterns for digits 0..9
package calc_display_pkg;

    localparam int NUM_POS = 6;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    // Entry [d] holds the pattern for digit d; the concatenation lists 9 down to 0.
    localparam logic [9:0][6:0] DIGIT_SEG = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

endpackage

// File: rtl/calc_display_driver_bcd_to_seg.sv
// bcd_to_seg
// Combinational BCD to 7-segment decoder (active-low outputs).
//   digit : 4-bit BCD code
//   seg   : {g,f,e,d,c,b,a}, active-low; codes 10..15 render as "E"
module bcd_to_seg
    import calc_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        if (digit <= 4'd9) begin
            seg = DIGIT_SEG[digit];
        end
    end

endmodule

// File: rtl/calc_display_driver.sv
// calc_display_driver
// Time-multiplexed 7-segment driver for the BCD calculator result bus.
// Six positions are scanned: units, tens, hundreds, thousands,
// ten-thousands and a floating minus-sign position. Leading zeros are
// blanked and the sign sits just left of the most significant digit.
// Inputs are captured once per frame so a scan never shows a torn value.
//   Clock      : system clock, rising edge
//   Reset      : asynchronous, active-high
//   Dig0..Dig3 : BCD digits (units..thousands)
//   Dig4       : ten-thousands digit (0/1)
//   DigMinus   : result is negative
//   Blank      : force all anodes off; scanning continues
//   Seg        : segments {g,f,e,d,c,b,a}, active-low
//   Anode      : position select, active-low one-hot, bit 0 = units
//   FrameStart : one-cycle pulse at the start of slot 0
module calc_display_driver
    import calc_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
)
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Dig0,
    input  logic [3:0] Dig1,
    input  logic [3:0] Dig2,
    input  logic [3:0] Dig3,
    input  logic       Dig4,
    input  logic       DigMinus,
    input  logic       Blank,
    output logic [6:0] Seg,
    output logic [5:0] Anode,
    output logic       FrameStart
);

    localparam int               CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       LAST_SLOT = 3'(NUM_POS - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       slot;
    logic [3:0][3:0]  snapdig;
    logic             snapdig4;
    logic             snapminus;

    logic             cntlast;
    logic [3:0]       posval [NUM_POS];
    logic [2:0]       msd;
    logic             anynonzero;
    logic [3:0]       curval;
    logic [6:0]       digitseg;
    logic             showdigit;
    logic             showminus;
    logic [6:0]       nextseg;
    logic [5:0]       nextanode;

    assign cntlast = (cnt == CNT_LAST);

    // Slot timer and slot index; the input snapshot is taken on the very
    // last cycle of the frame so the whole next frame uses one value.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt       <= '0;
            slot      <= '0;
            snapdig   <= '0;
            snapdig4  <= 1'b0;
            snapminus <= 1'b0;
        end else begin
            if (cntlast) begin
                cnt <= '0;
                if (slot == LAST_SLOT) begin
                    slot      <= '0;
                    snapdig   <= {Dig3, Dig2, Dig1, Dig0};
                    snapdig4  <= Dig4;
                    snapminus <= DigMinus;
                end else begin
                    slot <= slot + 3'd1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Find the most significant non-zero position (invalid codes count as
    // non-zero) and pick the value belonging to the current slot.
    always_comb begin
        posval[0] = snapdig[0];
        posval[1] = snapdig[1];
        posval[2] = snapdig[2];
        posval[3] = snapdig[3];
        posval[4] = {3'b000, snapdig4};
        posval[5] = 4'd0;

        msd        = 3'd0;
        anynonzero = 1'b0;
        for (int p = 0; p < NUM_POS - 1; p++) begin
            if (posval[p] != 4'd0) begin
                msd        = 3'(p);
                anynonzero = 1'b1;
            end
        end

        case (slot)
            3'd0:    curval = posval[0];
            3'd1:    curval = posval[1];
            3'd2:    curval = posval[2];
            3'd3:    curval = posval[3];
            3'd4:    curval = posval[4];
            default: curval = 4'd0;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .digit (curval),
        .seg   (digitseg)
    );

    // Decide what the next registered output is. Cycle 0 of each slot is a
    // dark gap so the previous digit does not ghost onto the new anode.
    // Negative zero never gets a sign because anynonzero gates it.
    always_comb begin
        showdigit = (slot <= msd);
        showminus = snapminus && anynonzero && (slot == 3'(msd + 3'd1));

        nextseg   = SEG_BLANK;
        nextanode = 6'h3F;
        if (cnt != '0 && !Blank) begin
            if (showdigit) begin
                nextseg   = digitseg;
                nextanode = ~(6'b000001 << slot);
            end else if (showminus) begin
                nextseg   = SEG_MINUS;
                nextanode = ~(6'b000001 << slot);
            end
        end
    end

    // Registered outputs, one cycle behind the scan state.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Seg        <= SEG_BLANK;
            Anode      <= 6'h3F;
            FrameStart <= 1'b0;
        end else begin
            Seg        <= nextseg;
            Anode      <= nextanode;
            FrameStart <= (slot == 3'd0) && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_calc_display_driver.sv
// tb_calc_display_driver
// Randomized and directed stimulus for calc_display_driver with a
// behavioural reference model based on cycle arithmetic since reset.
module tb_calc_display_driver;

    localparam int DIV = 4;
    localparam int POS = 6;
    localparam int FRAME = DIV * POS;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] Dig0, Dig1, Dig2, Dig3;
    logic       Dig4, DigMinus, Blank;
    logic [6:0] Seg;
    logic [5:0] Anode;
    logic       FrameStart;

    int testsRun = 0;
    int testsFailed = 0;

    // Model state: cycles since reset release and the captured frame value.
    int k;
    int snap[5];
    int snapNeg;

    calc_display_driver #(.REFRESH_DIV(DIV)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Dig0       (Dig0),
        .Dig1       (Dig1),
        .Dig2       (Dig2),
        .Dig3       (Dig3),
        .Dig4       (Dig4),
        .DigMinus   (DigMinus),
        .Blank      (Blank),
        .Seg        (Seg),
        .Anode      (Anode),
        .FrameStart (FrameStart)
    );

    always #5 Clock = ~Clock;

    // Compare one observed value with its expected value and log mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Active-low pattern for a position value, straight from the digit chart.
    function automatic logic [6:0] segFor(input int v);
        logic [6:0] table10 [10];
        table10 = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (v > 9) return 7'b0000110;
        return table10[v];
    endfunction

    // Expected outputs for the cycle after a scan position (c, s).
    task automatic computeExpected(input int c, input int s, output logic [6:0] es,
                                   output logic [5:0] ea, output logic ef, output bit segValid);
        int msd;
        bit anyNz;
        msd = 0;
        anyNz = 0;
        for (int p = 0; p < 5; p++) begin
            if (snap[p] != 0) begin
                msd = p;
                anyNz = 1;
            end
        end
        ef = (s == 0 && c == 0);
        es = 7'h7F;
        ea = 6'h3F;
        segValid = (Blank == 1'b0);
        if (c != 0 && Blank == 1'b0) begin
            if (s <= msd) begin
                es = segFor(snap[s]);
                ea = 6'h3F ^ (6'(1) << s);
            end else if (s == msd + 1 && snapNeg != 0 && anyNz) begin
                es = 7'b0111111;
                ea = 6'h3F ^ (6'(1) << s);
            end
        end
    endtask

    // Advance one clock, update the model and check all outputs.
    task automatic tick();
        int c, s;
        logic [6:0] es;
        logic [5:0] ea;
        logic ef;
        bit segValid;
        c = k % DIV;
        s = (k / DIV) % POS;
        computeExpected(c, s, es, ea, ef, segValid);
        @(posedge Clock);
        if (c == DIV - 1 && s == POS - 1) begin
            snap[0] = int'(Dig0);
            snap[1] = int'(Dig1);
            snap[2] = int'(Dig2);
            snap[3] = int'(Dig3);
            snap[4] = int'(Dig4);
            snapNeg = int'(DigMinus);
        end
        k++;
        #1;
        checkOutput("anode", 32'(Anode), 32'(ea));
        if (segValid) checkOutput("seg", 32'(Seg), 32'(es));
        checkOutput("framestart", 32'(FrameStart), 32'(ef));
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the next scan position is cycle 0 of the given slot.
    task automatic runToSlot(input int target);
        for (int i = 0; i < FRAME; i++) begin
            if ((k % DIV) == 0 && ((k / DIV) % POS) == target) break;
            tick();
        end
    endtask

    task automatic applyStimulus(input int d4, input int d3, input int d2, input int d1,
                                 input int d0, input int neg);
        Dig4 = 1'(d4);
        Dig3 = 4'(d3);
        Dig2 = 4'(d2);
        Dig1 = 4'(d1);
        Dig0 = 4'(d0);
        DigMinus = 1'(neg);
    endtask

    function automatic int randDigit();
        if ($urandom_range(0, 2) == 0) return 0;
        return int'($urandom_range(0, 15));
    endfunction

    task automatic modelReset();
        k = 0;
        snapNeg = 0;
        for (int p = 0; p < 5; p++) snap[p] = 0;
    endtask

    initial begin
        Reset = 1'b1;
        Blank = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        modelReset();
        #1;
        checkOutput("reset_seg", 32'(Seg), 32'h7F);
        checkOutput("reset_anode", 32'(Anode), 32'h3F);
        checkOutput("reset_fs", 32'(FrameStart), 32'h0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // First frames show the zero snapshot: only "0" on the units position.
        runTicks(FRAME);

        // 42, positive: two digits lit.
        applyStimulus(0, 0, 0, 4, 2, 0);
        runTicks(2 * FRAME);

        // -19999: all five digits plus sign on position 5.
        applyStimulus(1, 9, 9, 9, 9, 1);
        runTicks(2 * FRAME);

        // -7: sign on tens position.
        applyStimulus(0, 0, 0, 0, 7, 1);
        runTicks(2 * FRAME);

        // Negative zero: no sign.
        applyStimulus(0, 0, 0, 0, 0, 1);
        runTicks(2 * FRAME);

        // Mid-frame change is held off until the next frame.
        applyStimulus(0, 0, 0, 0, 3, 0);
        runToSlot(0);
        runTicks(FRAME);
        runToSlot(2);
        Dig0 = 4'hC;
        runTicks(2 * FRAME);

        // Blank for two frames, then resume with no phase shift.
        applyStimulus(0, 1, 2, 3, 4, 1);
        runToSlot(3);
        Blank = 1'b1;
        runTicks(2 * FRAME);
        Blank = 1'b0;
        runTicks(FRAME);

        // Asynchronous reset in the middle of slot 3.
        runToSlot(3);
        tick();
        Reset = 1'b1;
        #1;
        checkOutput("midreset_seg", 32'(Seg), 32'h7F);
        checkOutput("midreset_anode", 32'(Anode), 32'h3F);
        checkOutput("midreset_fs", 32'(FrameStart), 32'h0);
        modelReset();
        @(posedge Clock);
        #1;
        checkOutput("heldreset_anode", 32'(Anode), 32'h3F);
        Reset = 1'b0;
        runTicks(2 * FRAME);

        // Random values, random change times, occasional blanking.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(int'($urandom_range(0, 1)), randDigit(), randDigit(), randDigit(),
                          randDigit(), int'($urandom_range(0, 1)));
            Blank = ($urandom_range(0, 7) == 0);
            runTicks(int'($urandom_range(1, 40)));
        end
        Blank = 1'b0;
        runTicks(2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/calc_display_driver.md
Name: calc_display_driver

Overview:
Multiplexed 7-segment display driver for the BCD calculator's result bus (Dig0..Dig3 BCD, Dig4 overflow bit, DigMinus sign). It time-multiplexes six display positions: units, tens, hundreds, thousands, ten-thousands, and a floating sign position. It applies leading-zero blanking and places the minus sign immediately left of the most significant shown digit. Inputs are snapshotted once per frame so the display never tears when the calculator updates mid-scan.

Parameters:
REFRESH_DIV, 50000, clock cycles per display position slot; must be >= 2.
NUM_POS, 6, number of display positions. Fixed; held as a package constant, not overridable.

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Dig0  input  4  BCD units digit from calculator
Dig1  input  4  BCD tens digit
Dig2  input  4  BCD hundreds digit
Dig3  input  4  BCD thousands digit
Dig4  input  1  ten-thousands digit (0 or 1)
DigMinus  input  1  result is negative
Blank  input  1  force display dark; scan keeps running
Seg  output  7  segments {g,f,e,d,c,b,a}, active-low
Anode  output  6  position select, active-low one-hot; bit 0 = units
FrameStart  output  1  one-cycle pulse at start of slot 0 of each frame

Behaviour:
- Reset (async, immediate): Seg=7'h7F, Anode=6'h3F, FrameStart=0, cnt=0, slot=0, snapshot of all inputs=0. Reset asserted mid-frame blanks outputs in the same cycle.
- Scan counters: cnt increments every clock. When cnt==REFRESH_DIV-1: cnt<=0 and slot<=slot+1, wrapping 5->0.
- Snapshot: when cnt==REFRESH_DIV-1 and slot==5, capture Dig0..Dig4 and DigMinus. The displayed value is constant for a whole frame.
- Outputs are registered with one-cycle latency. Seg, Anode and FrameStart in cycle n+1 are a function of slot, cnt and snapshot in cycle n.
- Dead time: Anode=6'h3F and Seg=7'h7F for the cycle corresponding to cnt==0 of every slot (anti-ghosting).
- FrameStart=1 for exactly the cycle corresponding to slot==0, cnt==0. This includes the first frame after reset.
- Digit codes (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, minus=0111111, E=0000110, blank=1111111.
- Invalid BCD (>9) on Dig0..Dig3 displays E and counts as non-zero for blanking.
- Most significant shown position msd: the highest position p in 0..4 whose value is non-zero; msd=0 if all are zero. Position 0 is always shown.
- Positions <= msd show their digit.
- Position msd+1 shows minus if snapshot DigMinus=1 and any digit is non-zero. Negative zero shows no sign.
- All other positions are blank, with their Anode bit held high (off) for the whole slot.
- Blank=1 drives Anode=6'h3F with the same one-cycle latency. cnt, slot, snapshot and FrameStart are unaffected.
- Active slot outside dead time: exactly one Anode bit is low, equal to ~(1<<slot).

Decomposition:
- Package calc_display_pkg holds: NUM_POS; segment constants SEG_BLANK, SEG_MINUS, SEG_E; and a 10-entry digit code table.
- Sub-module bcd_to_seg (combinational): 4-bit digit in, 7-bit active-low pattern out, E for codes 10..15.
- The top level holds the counters, snapshot, blanking/sign logic and output registers.

Test Plan:
- Run all scenarios with REFRESH_DIV=4.
1. Reset pulse mid-frame at slot 3 -> Seg=7F and Anode=3F in the same cycle. After release, FrameStart pulses once every 24 cycles and each slot has 1 dead cycle.
2. Dig4..0=0,0,0,4,2, DigMinus=0 -> units slot: Anode=3E, Seg=0100100. Tens slot: Anode=3D, Seg=0011001. Slots 2..5: Anode=3F.
3. Dig4..0=1,9,9,9,9, DigMinus=1 -> position 4 Seg=1111001, positions 0..3 Seg=0010000, position 5 Seg=0111111 with Anode=1F.
4. Dig4..0=0,0,0,0,7, DigMinus=1 -> position 0 shows 7; position 1 shows minus (Anode=3D, Seg=0111111); positions 2..5 dark. All zero with DigMinus=1 -> only position 0 lit showing 1000000.
5. Change Dig0 from 3 to 4'hC during slot 2 -> position 0 keeps showing 3 for the rest of the frame. Next frame shows E (0000110).
6. Blank=1 for two frames -> Anode=3F throughout while FrameStart keeps pulsing. On deassertion, the display resumes on the next cycle with no slot-phase shift.
